board_store: RTL

BOARD_STORE -- requirements
Module: board_store

---
 rtl/board_store.sv | 105 ++++++++++
 1 files changed

// File: rtl/board_store.sv
// 20x10 playfield store with a combinational read port, a registered renderer
// row port, and a line-clear engine that removes full rows and shifts rows down.
module board_store (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [3:0] board_rx,
  input  logic [4:0] board_ry,
  output logic       board_rdata,
  input  logic       board_we,
  input  logic [3:0] board_wx,
  input  logic [4:0] board_wy,
  input  logic       board_wdata,
  input  logic       clear_start,
  output logic       clear_busy,
  output logic       clear_done,
  output logic [4:0] lines_cleared,
  input  logic [4:0] vid_ry,
  output logic [9:0] vid_row
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [9:0] row_q [20];
  logic [1:0] st_q, st_d;
  logic [4:0] r_q, r_d;
  logic [4:0] k_q, k_d;
  logic [4:0] lc_q, lc_d;
  logic [9:0] vid_q;
  logic       wr_ok;

  assign wr_ok = (st_q == S_IDLE) && board_we && (board_wx <= 4'd9) && (board_wy <= 5'd19);

  assign board_rdata   = (board_rx <= 4'd9 && board_ry <= 5'd19) ? row_q[board_ry][board_rx] : 1'b0;
  assign clear_busy    = (st_q != S_IDLE);
  assign clear_done    = (st_q == S_DONE);
  assign lines_cleared = lc_q;
  assign vid_row       = vid_q;

  always_comb begin
    st_d = st_q;
    r_d  = r_q;
    k_d  = k_q;
    lc_d = lc_q;
    case (st_q)
      S_IDLE: if (clear_start) begin
        st_d = S_SCAN;
        r_d  = 5'd19;
        lc_d = 5'd0;
      end
      S_SCAN: begin
        if (row_q[r_q] == 10'h3FF) begin
          k_d  = r_q;
          st_d = S_SHIFT;
        end else if (r_q == 5'd0) begin
          st_d = S_DONE;
        end else begin
          r_d = r_q - 5'd1;
        end
      end
      // r is left alone so the row that just received the one above is re-examined
      S_SHIFT: begin
        if (k_q == 5'd0) begin
          lc_d = lc_q + 5'd1;
          st_d = S_SCAN;
        end else begin
          k_d = k_q - 5'd1;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      st_q  <= S_IDLE;
      r_q   <= 5'd0;
      k_q   <= 5'd0;
      lc_q  <= 5'd0;
      vid_q <= 10'd0;
    end else begin
      st_q  <= st_d;
      r_q   <= r_d;
      k_q   <= k_d;
      lc_q  <= lc_d;
      vid_q <= (vid_ry <= 5'd19) ? row_q[vid_ry] : 10'd0;
    end
  end

  // Writes only land in IDLE, so they never collide with a shift
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      for (int i = 0; i < 20; i++) row_q[i] <= 10'd0;
    end else begin
      if (wr_ok) row_q[board_wy][board_wx] <= board_wdata;
      if (st_q == S_SHIFT) begin
        if (k_q == 5'd0) row_q[0] <= 10'd0;
        else             row_q[k_q] <= row_q[k_q - 5'd1];
      end
    end
  end

endmodule
